// File: rtl/column_loader.sv
// column_loader: collects a frame of NCOL columns from a narrow valid/ready beat
// stream into a shadow buffer, then publishes every column in a single cycle so
// the downstream column register never sees a partially written frame.
module column_loader #(
   parameter int COL_W  = 25,
   parameter int BEAT_W = 5,
   parameter int NCOL   = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [BEAT_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_first,
   output logic              in_ready,
   output logic [COL_W-1:0]  out0,
   output logic [COL_W-1:0]  out1,
   output logic [COL_W-1:0]  out2,
   output logic [COL_W-1:0]  out3,
   output logic [COL_W-1:0]  out4,
   output logic              frame_done,
   output logic              sync_err
);

   localparam int BPC = COL_W / BEAT_W;
   localparam int BIW = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int CIW = (NCOL > 1) ? $clog2(NCOL) : 1;
   localparam logic [BIW-1:0] BEAT_LAST = BIW'(BPC - 1);
   localparam logic [CIW-1:0] COL_LAST  = CIW'(NCOL - 1);

   typedef enum logic {
      LOAD,
      PUBLISH
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CIW-1:0]   col_idx;
   logic [CIW-1:0]   col_idx_next;
   logic [BIW-1:0]   beat_idx;
   logic [BIW-1:0]   beat_idx_next;
   logic [COL_W-1:0] shadow      [NCOL];
   logic [COL_W-1:0] shadow_next [NCOL];
   logic [COL_W-1:0] out_q       [NCOL];
   logic             accept;
   logic             at_start;
   logic             at_last;
   logic             resync;

   // State register; reset returns to LOAD ahead of everything else.
   always_ff @(posedge clock) begin
      // NOTE: every clocked assignment is non-blocking so all registers sample
      // the pre-edge values and the block order cannot change behaviour.
      if (reset) state <= LOAD;
      else       state <= state_next;
   end

   // Next-state, handshake and beat position bookkeeping.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_next    = state;
      in_ready      = 1'b0;
      col_idx_next  = col_idx;
      beat_idx_next = beat_idx;
      at_start      = (col_idx == '0) && (beat_idx == '0);
      at_last       = (col_idx == COL_LAST) && (beat_idx == BEAT_LAST);
      accept        = 1'b0;
      resync        = 1'b0;

      case (state)
         LOAD: begin
            in_ready = 1'b1;
            accept   = in_valid;
            resync   = in_valid && in_first && !at_start;
            if (resync) begin
               // The marker restarts the frame: this beat becomes beat 0.
               col_idx_next  = '0;
               beat_idx_next = BIW'(1);
            end else if (accept) begin
               if (at_last) begin
                  col_idx_next  = '0;
                  beat_idx_next = '0;
                  state_next    = PUBLISH;
               end else if (beat_idx == BEAT_LAST) begin
                  col_idx_next  = col_idx + CIW'(1);
                  beat_idx_next = '0;
               end else begin
                  beat_idx_next = beat_idx + BIW'(1);
               end
            end
         end
         PUBLISH: state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   // Shadow write: drop the accepted beat into its column/beat slot.
   always_comb begin
      shadow_next = shadow;
      if (resync) begin
         shadow_next[0][BEAT_W-1:0] = in_data;
      end else if (accept) begin
         for (int c = 0; c < NCOL; c++) begin
            for (int b = 0; b < BPC; b++) begin
               if (col_idx == CIW'(c) && beat_idx == BIW'(b))
                  shadow_next[c][b*BEAT_W +: BEAT_W] = in_data;
            end
         end
      end
   end

   // Datapath registers: indices, shadow, published columns and status pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         col_idx    <= '0;
         beat_idx   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         // NOTE: the shadow buffer is cleared on reset too; it is small, and a
         // known-zero shadow keeps stale columns deterministic after a resync.
         for (int c = 0; c < NCOL; c++) begin
            shadow[c] <= '0;
            out_q[c]  <= '0;
         end
      end else begin
         col_idx    <= col_idx_next;
         beat_idx   <= beat_idx_next;
         shadow     <= shadow_next;
         frame_done <= (state == PUBLISH);
         sync_err   <= resync;
         if (state == PUBLISH) begin
            for (int c = 0; c < NCOL; c++) out_q[c] <= shadow[c];
         end
      end
   end

   assign out0 = out_q[0];
   assign out1 = out_q[1];
   assign out2 = out_q[2];
   assign out3 = out_q[3];
   assign out4 = out_q[4];

endmodule
